// File: rtl/adder_arbiter_4b.sv
// adder_arbiter_4b: four requesters share one 4-bit adder through a
// three-state FSM (IDLE -> CAPT -> RESP). Round-robin arbitration by default.
// Define ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).

// Per-requester operand gate: passes this lane's slices only when granted,
// so the shared adder sees an OR of one-hot-masked operands.
module adder_arbiter_4b_lane #(
   parameter int VEC_W = 4
) (
   input  logic             sel,
   input  logic [VEC_W-1:0] a_in,
   input  logic [VEC_W-1:0] b_in,
   output logic [VEC_W-1:0] a_out,
   output logic [VEC_W-1:0] b_out
);
   assign a_out = sel ? a_in : '0;
   assign b_out = sel ? b_in : '0;
endmodule

module adder_arbiter_4b (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [15:0] a_bus,
   input  logic [15:0] b_bus,
   output logic [3:0]  gnt,
   output logic [3:0]  ack,
   output logic [3:0]  sum,
   output logic        carry,
   output logic        busy
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 4;
   localparam int PTR_W     = 2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CAPT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]                          state;
   logic [NUM_LANES-1:0][VEC_W-1:0]     a_vec, b_vec, a_m, b_m;
   logic [VEC_W-1:0]                    a_sel, b_sel;
   logic [VEC_W:0]                      add_res;
   logic [NUM_LANES-1:0]                win_oh;

   assign a_vec = a_bus;
   assign b_vec = b_bus;
   assign busy  = (state != IDLE);

`ifdef ARB_FIXED_PRIO_EN
   // Fixed priority: lowest-numbered requesting lane wins.
   always_comb begin
      win_oh = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (req[i] && (win_oh == '0)) win_oh[i] = 1'b1;
      end
   end
`else
   logic [PTR_W-1:0] ptr, ptr_nxt, idx;

   // Round-robin: search ptr, ptr+1, ... wrapping; next ptr is winner+1.
   always_comb begin
      win_oh  = '0;
      ptr_nxt = ptr;
      idx     = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = ptr + PTR_W'(k);
         if (req[idx] && (win_oh == '0)) begin
            win_oh[idx] = 1'b1;
            ptr_nxt     = idx + PTR_W'(1);
         end
      end
   end

   // Pointer advances only when a grant is issued from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    ptr <= '0;
      else if (state == IDLE && |req) ptr <= ptr_nxt;
   end
`endif

   // Operand gating per lane, driven by the registered one-hot grant.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      adder_arbiter_4b_lane #(.VEC_W(VEC_W)) u_lane (
         .sel   (gnt[i]),
         .a_in  (a_vec[i]),
         .b_in  (b_vec[i]),
         .a_out (a_m[i]),
         .b_out (b_m[i])
      );
   end

   // OR-reduce the masked slices into the shared adder inputs.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         a_sel = a_sel | a_m[i];
         b_sel = b_sel | b_m[i];
      end
   end

   assign add_res = {1'b0, a_sel} + {1'b0, b_sel};

   // Main FSM: grant in IDLE, capture/add in CAPT, one-cycle ack in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         ack   <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (|req) begin
                  gnt   <= win_oh;
                  state <= CAPT;
               end
            end
            CAPT: begin
               {carry, sum} <= add_res;
               ack          <= gnt;
               state        <= RESP;
            end
            RESP: begin
               ack   <= '0;
               gnt   <= '0;
               state <= IDLE;
            end
            default: begin
               ack   <= '0;
               gnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_adder_arbiter_4b.sv
// Bench for adder_arbiter_4b: vector table, hand sequences for reset and
// operand-stability corners, and randomized transactions against a
// transaction-level arbitration/add model.
module tb_adder_arbiter_4b;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] a_bus = '0, b_bus = '0;
   logic [3:0]  gnt, ack, sum;
   logic        carry, busy;

   int tests = 0;
   int fails = 0;

   adder_arbiter_4b dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
      .gnt(gnt), .ack(ack), .sum(sum), .carry(carry), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  r;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  g;
      logic [3:0]  s;
      logic        c;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_gnt"},   gnt,   16'h0);
      chk({nm, "_ack"},   ack,   16'h0);
      chk({nm, "_busy"},  busy,  16'h0);
   endtask

   // Starts at a negedge with the DUT in IDLE; returns at the next IDLE negedge.
   task automatic run_txn(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] a_late, input logic [3:0] eg,
                          input logic [3:0] es, input logic ec);
      req = r; a_bus = a; b_bus = b;
      @(negedge clk);
      chk("capt_gnt",  gnt,  eg);
      chk("capt_ack",  ack,  16'h0);
      chk("capt_busy", busy, 16'h1);
      @(negedge clk);
      chk("resp_gnt",   gnt,   eg);
      chk("resp_ack",   ack,   eg);
      chk("resp_sum",   sum,   es);
      chk("resp_carry", carry, ec);
      chk("resp_busy",  busy,  16'h1);
      a_bus = a_late;
      @(negedge clk);
      chk_zero("idle");
      chk("hold_sum",   sum,   es);
      chk("hold_carry", carry, ec);
   endtask

   task automatic do_reset(input logic [3:0] r);
      req   = r;
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("rst");
      chk("rst_sum",   sum,   16'h0);
      chk("rst_carry", carry, 16'h0);
      rst_n = 1'b1;
   endtask

   // Reference arbitration: index of the winning requester.
   function automatic int pick(input logic [3:0] r, input int p);
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
`endif
      return 0;
   endfunction

   initial begin
      logic [3:0] rr_exp[6];
      int mptr;

      // Reset state
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_zero("por");
      chk("por_sum", sum, 16'h0);
      chk("por_carry", carry, 16'h0);
      rst_n = 1'b1;

      // IDLE with no requests stays idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_zero("noreq");
      end

      // Vector table, applied straight after reset (ptr starts at 0)
      tbl[0] = '{4'b0001, 16'h0003, 16'h0004, 4'b0001, 4'd7,  1'b0};
      tbl[1] = '{4'b0100, 16'h0F00, 16'h0100, 4'b0100, 4'd0,  1'b1};
      tbl[2] = '{4'b0100, 16'h0F00, 16'h0F00, 4'b0100, 4'd14, 1'b1};
`ifdef ARB_FIXED_PRIO_EN
      tbl[3] = '{4'b1111, 16'h4321, 16'h1111, 4'b0001, 4'd2,  1'b0};
      tbl[4] = '{4'b1010, 16'h4321, 16'h1111, 4'b0010, 4'd3,  1'b0};
      tbl[5] = '{4'b0011, 16'h4321, 16'h1111, 4'b0001, 4'd2,  1'b0};
`else
      tbl[3] = '{4'b1111, 16'h4321, 16'h1111, 4'b1000, 4'd5,  1'b0};
      tbl[4] = '{4'b1010, 16'h4321, 16'h1111, 4'b0010, 4'd3,  1'b0};
      tbl[5] = '{4'b0011, 16'h4321, 16'h1111, 4'b0001, 4'd2,  1'b0};
`endif
      foreach (tbl[i])
         run_txn(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].a, tbl[i].g, tbl[i].s, tbl[i].c);

      // All requesters held continuously from reset, then drop req[0]
`ifdef ARB_FIXED_PRIO_EN
      rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif
      do_reset(4'b1111);
      for (int i = 0; i < 6; i++) begin
         logic [3:0] rq;
         logic [3:0] es;
         rq = (i == 5) ? 4'b1110 : 4'b1111;
         es = 4'(1 + $clog2(rr_exp[i]) + 1);
         run_txn(rq, 16'h4321, 16'h1111, 16'h4321, rr_exp[i], es, 1'b0);
      end

      // Reset during CAPT aborts with no ack; first grant after release
      req = 4'b0010; a_bus = '0; b_bus = '0;
      @(negedge clk);
      chk("abort_capt_gnt", gnt, 16'h2);
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      chk_zero("abort_capt");
      chk("abort_capt_sum", sum, 16'h0);
      chk("abort_capt_carry", carry, 16'h0);
      @(negedge clk);
      chk("abort_capt_ack1", ack, 16'h0);
      @(negedge clk);
      chk("abort_capt_ack2", ack, 16'h0);
      rst_n = 1'b1;
      run_txn(4'b0100, 16'h0300, 16'h0200, 16'h0300, 4'b0100, 4'd5, 1'b0);

      // Reset during RESP; pointer must restart at requester 0
      req = 4'b0010; a_bus = '0; b_bus = '0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_resp_ack", ack, 16'h2);
      rst_n = 1'b0;
      req   = 4'b1111; a_bus = 16'h4321; b_bus = 16'h1111;
      #1;
      chk_zero("abort_resp");
      @(negedge clk);
      chk("abort_resp_ack2", ack, 16'h0);
      rst_n = 1'b1;
      run_txn(4'b1111, 16'h4321, 16'h1111, 16'h4321, 4'b0001, 4'd2, 1'b0);

      // Operand change during RESP does not disturb the held result
      req = 4'b0000;
      @(negedge clk);
      run_txn(4'b0010, 16'h0050, 16'h0020, 16'h0090, 4'b0010, 4'd7, 1'b0);
      @(negedge clk);
      chk("late_a_sum", sum, 16'h7);

      // Randomized transactions against the reference model
      do_reset(4'b0000);
      mptr = 0;
      for (int n = 0; n < 200; n++) begin
         logic [3:0]  r;
         logic [15:0] a, b;
         int w, av, bv;
         if ($urandom_range(0, 7) == 0) begin
            req = 4'b0000;
            @(negedge clk);
            chk_zero("rnd_gap");
         end
         r  = 4'($urandom_range(1, 15));
         a  = 16'($urandom);
         b  = 16'($urandom);
         w  = pick(r, mptr);
         av = (a >> (4 * w)) & 15;
         bv = (b >> (4 * w)) & 15;
         run_txn(r, a, b, 16'($urandom), 4'(1 << w), 4'((av + bv) % 16), 1'((av + bv) / 16));
         mptr = (w + 1) % 4;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/adder_arbiter_4b.md
ADDER_ARBITER_4B -- requirements
Module: adder_arbiter_4b

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port req, input, 4 bits: req[i] high = requester i requests one 4-bit add.
REQ-004 The block SHALL have port a_bus, input, 16 bits: operand A of requester i in bits [4i+3:4i].
REQ-005 The block SHALL have port b_bus, input, 16 bits: operand B of requester i in bits [4i+3:4i].
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have port ack, output, 4 bits: one-hot, one-cycle completion pulse to the granted requester.
REQ-008 The block SHALL have port sum, output, 4 bits: registered result, (A+B) mod 16.
REQ-009 The block SHALL have port carry, output, 1 bit: registered carry-out, bit 4 of the 5-bit sum A+B.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CAPT, RESP.
REQ-012 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0 and ack=0.
REQ-013 In IDLE with req!=0, the block SHALL select one winner, set gnt to the winner (one-hot) and go to CAPT at the next edge.
REQ-014 In CAPT, the block SHALL capture the winner's A and B slices, compute the 5-bit sum in one shared adder, register sum/carry and go to RESP at the next edge.
REQ-015 In RESP, ack SHALL equal gnt for exactly one cycle, sum/carry SHALL be valid, and the FSM SHALL go to IDLE at the next edge.
REQ-016 On leaving RESP, gnt SHALL clear to 0.
REQ-017 Latency SHALL be fixed: req sampled in IDLE at cycle T; gnt high in T+1 and T+2; ack high in T+2; maximum throughput is one add per 3 cycles.
REQ-018 A requester SHALL hold req[i] and its operand slices stable from assertion until ack[i]; operand changes after capture SHALL NOT affect the result.
REQ-019 A req[i] still high in the IDLE cycle after ack[i] SHALL be treated as a new request.
REQ-020 Changes on req during CAPT or RESP SHALL be ignored; arbitration occurs only in IDLE.
REQ-021 Default arbitration SHALL be round-robin with a 2-bit pointer; search order is ptr, ptr+1, ..., wrapping 3 to 0.
REQ-022 After each grant, ptr SHALL be set to winner+1 mod 4.
REQ-023 The adder SHALL wrap on overflow: 15+1 gives sum=0, carry=1; 15+15 gives sum=14, carry=1.
REQ-024 sum and carry SHALL hold their last value until the next CAPT cycle.
REQ-025 gnt and ack SHALL never have more than one bit set.

Reset
REQ-026 While rst_n=0, regardless of clk, state SHALL be IDLE and gnt, ack, sum, carry, busy and ptr SHALL all be 0.
REQ-027 Reset asserted in CAPT or RESP SHALL abort the operation with no ack issued; the requester re-requests after reset.
REQ-028 After rst_n rises, the first arbitration SHALL start from requester 0.

Configuration
REQ-029 With ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest) and ptr SHALL be absent or unused.
REQ-030 Without ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-021 and REQ-022.
REQ-031 FSM timing, handshake and reset behaviour SHALL be identical in both builds.

Verification
REQ-032 Single requester: req=0001, A0=3, B0=4 -> gnt=0001 at T+1, ack=0001 at T+2, sum=7, carry=0, busy high for 2 cycles.
REQ-033 Overflow: requester 2 with A=15, B=1 -> sum=0, carry=1; then A=15, B=15 -> sum=14, carry=1.
REQ-034 Round-robin (default build): req=1111 held continuously from reset -> grants in order 0001, 0010, 0100, 1000, 0001, one every 3 cycles.
REQ-035 Fixed priority (ARB_FIXED_PRIO_EN build): req=1111 held -> every grant is 0001; drop req[0] -> next grant is 0010.
REQ-036 Reset mid-op: rst_n low during CAPT -> all outputs 0 immediately, no ack pulse; after release, req=0100 gives first grant 0100.
REQ-037 Operand stability: change A1 from 5 to 9 during RESP of a 5+2 operation -> ack with sum=7.
